// File: rtl/ltc2333_pkg.sv
// Shared types for the LTC2333 scan scheduler: FSM states, the latched job record
// and the SoftSpan range codes that requesters pass through to the engine.
package ltc2333_pkg;

   localparam int JOB_NCHAN   = 8;
   localparam int JOB_NREAD_W = 16;
   localparam int CNT_W       = 33;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} sched_state_t;

   typedef struct packed {
      logic [JOB_NCHAN-1:0]   mask;
      logic [JOB_NREAD_W-1:0] n_reads;
      logic [2:0]             range;
      logic [31:0]            period;
   } scan_job_t;

   localparam logic [2:0] SPAN_0V_5V00    = 3'd0;
   localparam logic [2:0] SPAN_0V_5V12    = 3'd1;
   localparam logic [2:0] SPAN_PM_5V00    = 3'd2;
   localparam logic [2:0] SPAN_PM_5V12    = 3'd3;
   localparam logic [2:0] SPAN_0V_10V00   = 3'd4;
   localparam logic [2:0] SPAN_0V_10V24   = 3'd5;
   localparam logic [2:0] SPAN_PM_10V00   = 3'd6;
   localparam logic [2:0] SPAN_PM_10V24   = 3'd7;

   function automatic int rrNext(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/ltc2333_scan_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         cand = IDX_W'((int'(ptr_i) + i) % N);
         if (!any_o && req_i[cand]) begin
            any_o         = 1'b1;
            idx_o         = cand;
            grant_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ltc2333_scan_scheduler.sv
// Shares one LTC2333 engine between N_REQ requesters: round-robin grant, parameter
// load with the engine held in reset, cnv-counted completion, drain guard and timeout.
module ltc2333_scan_scheduler
   import ltc2333_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int NCHAN          = JOB_NCHAN,
   parameter int NREAD_W        = JOB_NREAD_W,
   parameter int LOAD_CYCLES    = 4,
   parameter int DRAIN_CYCLES   = 64,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                     clk,
   input  logic                     areset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*NCHAN-1:0]   req_chan_mask,
   input  logic [N_REQ*NREAD_W-1:0] req_n_reads,
   input  logic [N_REQ*3-1:0]       req_range,
   input  logic [N_REQ*32-1:0]      req_period,
   output logic                     eng_reset,
   output logic                     eng_mode,
   output logic [NCHAN-1:0]         eng_active_channels,
   output logic [NREAD_W-1:0]       eng_n_reads,
   output logic [2:0]               eng_range,
   output logic [31:0]              eng_sample_period,
   input  logic                     cnv,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     done,
   output logic [$clog2(N_REQ)-1:0] done_id,
   output logic                     done_err
);

   localparam int IDX_W = $clog2(N_REQ);

   sched_state_t           state_q, state_d;
   logic [IDX_W-1:0]       rrPtr_q, rrPtr_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [N_REQ-1:0]       ready_q, ready_d;
   scan_job_t              job_q, job_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [JOB_NREAD_W-1:0] riseCnt_q, riseCnt_d;
   logic                   err_q, err_d;
   logic                   done_q, done_d;
   logic [IDX_W-1:0]       doneId_q, doneId_d;
   logic                   doneErr_q, doneErr_d;
   logic                   cnv_q;

   logic [N_REQ-1:0]       arbOnehot;
   logic [IDX_W-1:0]       arbIdx;
   logic                   arbAny;
   logic                   cnvRise;
   logic [CNT_W-1:0]       drainTarget;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req_i   (req_valid),
      .ptr_i   (rrPtr_q),
      .grant_o (arbOnehot),
      .idx_o   (arbIdx),
      .any_o   (arbAny)
   );

   assign cnvRise     = cnv & ~cnv_q;
   assign drainTarget = {1'b0, job_q.period} + CNT_W'(DRAIN_CYCLES);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         rrPtr_q   <= '0;
         grant_q   <= '0;
         ready_q   <= '0;
         job_q     <= '0;
         cnt_q     <= '0;
         riseCnt_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         doneId_q  <= '0;
         doneErr_q <= 1'b0;
         cnv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rrPtr_q   <= rrPtr_d;
         grant_q   <= grant_d;
         ready_q   <= ready_d;
         job_q     <= job_d;
         cnt_q     <= cnt_d;
         riseCnt_q <= riseCnt_d;
         err_q     <= err_d;
         done_q    <= done_d;
         doneId_q  <= doneId_d;
         doneErr_q <= doneErr_d;
         cnv_q     <= cnv;
      end
   end

   // IDLE is two-phase: pick a winner and raise its ready, then latch its fields
   // during the ready cycle so the requester sees exactly what was captured.
   always_comb begin
      state_d   = state_q;
      rrPtr_d   = rrPtr_q;
      grant_d   = grant_q;
      ready_d   = '0;
      job_d     = job_q;
      cnt_d     = cnt_q;
      riseCnt_d = riseCnt_q;
      err_d     = err_q;
      done_d    = 1'b0;
      doneId_d  = doneId_q;
      doneErr_d = doneErr_q;
      unique case (state_q)
         IDLE: begin
            if (ready_q == '0) begin
               if (arbAny) begin
                  ready_d = arbOnehot;
                  grant_d = arbIdx;
                  rrPtr_d = IDX_W'(rrNext(int'(arbIdx), N_REQ));
               end
            end else begin
               job_d.mask    = JOB_NCHAN'(req_chan_mask[int'(grant_q)*NCHAN +: NCHAN]);
               job_d.n_reads = JOB_NREAD_W'(req_n_reads[int'(grant_q)*NREAD_W +: NREAD_W]);
               job_d.range   = req_range[int'(grant_q)*3 +: 3];
               job_d.period  = req_period[int'(grant_q)*32 +: 32];
               cnt_d         = '0;
               riseCnt_d     = '0;
               if (job_d.n_reads == '0 || job_d.mask == '0) begin
                  err_d   = (job_d.mask == '0);
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            riseCnt_d = '0;
            if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (cnvRise) begin
               riseCnt_d = riseCnt_q + 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (riseCnt_q == job_q.n_reads && !cnv) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else if (!cnvRise && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DRAIN: begin
            if (cnt_q + 1'b1 >= drainTarget) begin
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            done_d    = 1'b1;
            doneId_d  = grant_q;
            doneErr_d = err_q;
            cnt_d     = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The engine only runs in RUN and DRAIN; every other state parks it in reset.
   always_comb begin
      eng_reset = 1'b1;
      busy      = 1'b0;
      if (state_q == RUN || state_q == DRAIN) begin
         eng_reset = 1'b0;
      end
      if (state_q != IDLE) begin
         busy = 1'b1;
      end
   end

   assign eng_mode            = 1'b0;
   assign eng_active_channels = NCHAN'(job_q.mask);
   assign eng_n_reads         = NREAD_W'(job_q.n_reads);
   assign eng_range           = job_q.range;
   assign eng_sample_period   = job_q.period;
   assign req_ready           = ready_q;
   assign grant_id            = grant_q;
   assign done                = done_q;
   assign done_id             = doneId_q;
   assign done_err            = doneErr_q;

endmodule

// File: tb/tb_ltc2333_scan_scheduler.sv
// Scoreboard bench for ltc2333_scan_scheduler with a behavioural engine that emits
// one cnv pulse per read, spaced sample_period+15 cycles, after each reset release.
`timescale 1ns/1ps
module tb_ltc2333_scan_scheduler;

   localparam int N_REQ   = 4;
   localparam int NCHAN   = 8;
   localparam int NREAD_W = 16;
   localparam int TIMEOUT = 1000;

   logic                     clk = 1'b0;
   logic                     areset = 1'b1;
   logic [N_REQ-1:0]         req_valid = '0;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ*NCHAN-1:0]   req_chan_mask = '0;
   logic [N_REQ*NREAD_W-1:0] req_n_reads = '0;
   logic [N_REQ*3-1:0]       req_range = '0;
   logic [N_REQ*32-1:0]      req_period = '0;
   logic                     eng_reset, eng_mode;
   logic [NCHAN-1:0]         eng_active_channels;
   logic [NREAD_W-1:0]       eng_n_reads;
   logic [2:0]               eng_range;
   logic [31:0]              eng_sample_period;
   logic                     cnv = 1'b0;
   logic                     busy, done, done_err;
   logic [1:0]               grant_id, done_id;

   typedef struct packed {
      logic [7:0] id;
      logic       err;
   } doneExp_t;

   doneExp_t expDone[$];
   int       expGrant[$];

   int checks = 0, failures = 0;
   int cyc = 0;
   int grantSeen = 0, doneCount = 0, relCount = 0, riseCount = 0;
   int readyCyc = 0, doneCyc = 0, lastRiseCyc = 0, lastFallCyc = 0, resetRiseCyc = 0;
   int postCyc = 0;
   int stallAfter = 0;
   int mPhase = 0, mPulses = 0, mLimit = 0;
   logic cnvPrev = 1'b0, engResetPrev = 1'b1;
   logic [N_REQ-1:0] dropMask;

   ltc2333_scan_scheduler #(
      .N_REQ(N_REQ), .NCHAN(NCHAN), .NREAD_W(NREAD_W),
      .LOAD_CYCLES(4), .DRAIN_CYCLES(64), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_chan_mask(req_chan_mask), .req_n_reads(req_n_reads),
      .req_range(req_range), .req_period(req_period),
      .eng_reset(eng_reset), .eng_mode(eng_mode),
      .eng_active_channels(eng_active_channels), .eng_n_reads(eng_n_reads),
      .eng_range(eng_range), .eng_sample_period(eng_sample_period),
      .cnv(cnv), .busy(busy), .grant_id(grant_id),
      .done(done), .done_id(done_id), .done_err(done_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic applyStimulus(input int id, input logic [7:0] mask, input int n,
                                input logic [2:0] rng, input int per);
      req_chan_mask[id*NCHAN +: NCHAN]     = mask;
      req_n_reads[id*NREAD_W +: NREAD_W]   = NREAD_W'(n);
      req_range[id*3 +: 3]                 = rng;
      req_period[id*32 +: 32]              = per;
      req_valid[id]                        = 1'b1;
      postCyc                              = cyc;
   endtask

   task automatic waitFor(input string name, input int which, input int target, input int budget);
      int k = 0;
      int val;
      val = (which == 0) ? doneCount : (which == 1) ? grantSeen : relCount;
      while (val < target && k < budget) begin
         @(negedge clk);
         k++;
         val = (which == 0) ? doneCount : (which == 1) ? grantSeen : relCount;
      end
      if (val < target) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: timed out, got %0d, expected %0d", name, val, target);
      end
   endtask

   function automatic int idxOf(input logic [N_REQ-1:0] v);
      for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Behavioural engine: restarts whenever eng_reset is high.
   always @(posedge clk) begin
      #1;
      if (eng_reset) begin
         mPhase  = 0;
         mPulses = 0;
         cnv     = 1'b0;
      end else begin
         mLimit = (stallAfter != 0) ? stallAfter : int'(eng_n_reads);
         cnv    = (mPulses < mLimit) && (mPhase >= 2) && (mPhase < 5);
         if (mPhase >= int'(eng_sample_period) + 14) begin
            mPhase = 0;
            mPulses++;
         end else begin
            mPhase++;
         end
      end
   end

   // Requesters drop valid just after the edge that closes their ready cycle.
   always @(negedge clk) begin
      dropMask = req_ready;
      if (dropMask != '0) begin
         @(posedge clk);
         #1;
         req_valid = req_valid & ~dropMask;
      end
   end

   // Monitor: compares grants and completions against the scoreboard queues.
   always @(negedge clk) begin
      doneExp_t de;
      int g;
      if (req_ready != '0) begin
         readyCyc = cyc;
         grantSeen++;
         checkOutput("ready_onehot", 64'($onehot(req_ready)), 64'd1);
         if (expGrant.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ready: got ready=%b, expected none", req_ready);
         end else begin
            g = expGrant.pop_front();
            checkOutput("grant_order", 64'(idxOf(req_ready)), 64'(g));
            checkOutput("grant_id", 64'(grant_id), 64'(g));
         end
      end
      if (done) begin
         doneCyc = cyc;
         doneCount++;
         if (expDone.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_done: got done_id=%0d, expected no done", done_id);
         end else begin
            de = expDone.pop_front();
            checkOutput("done_id", 64'(done_id), 64'(de.id));
            checkOutput("done_err", 64'(done_err), 64'(de.err));
         end
      end
      if (cnv && !cnvPrev) begin
         riseCount++;
         lastRiseCyc = cyc;
      end
      if (!cnv && cnvPrev) lastFallCyc = cyc;
      if (!eng_reset && engResetPrev) begin
         relCount++;
         riseCount = 0;
      end
      if (eng_reset && !engResetPrev) resetRiseCyc = cyc;
      cnvPrev      = cnv;
      engResetPrev = eng_reset;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rel;

      repeat (3) @(negedge clk);
      checkOutput("rst_eng_reset", 64'(eng_reset), 64'd1);
      checkOutput("rst_eng_mode", 64'(eng_mode), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_n_reads", 64'(eng_n_reads), 64'd0);
      checkOutput("rst_mask", 64'(eng_active_channels), 64'd0);
      @(posedge clk); #1 areset = 1'b0;

      // 1: single job on req0
      expGrant.push_back(0);
      expDone.push_back('{id: 8'd0, err: 1'b0});
      @(posedge clk); #2;
      applyStimulus(0, 8'h05, 3, 3'd2, 100);
      waitFor("t1_grant", 1, 1, 20);
      checkOutput("t1_ready_latency", 64'(readyCyc - postCyc), 64'd1);
      repeat (10) @(negedge clk);
      checkOutput("t1_eng_mask", 64'(eng_active_channels), 64'h05);
      checkOutput("t1_eng_n", 64'(eng_n_reads), 64'd3);
      checkOutput("t1_eng_per", 64'(eng_sample_period), 64'd100);
      checkOutput("t1_eng_range", 64'(eng_range), 64'd2);
      checkOutput("t1_busy", 64'(busy), 64'd1);
      req_n_reads[0 +: NREAD_W]  = 16'd7;
      req_chan_mask[0 +: NCHAN]  = 8'hAA;
      waitFor("t1_done", 0, 1, 2000);
      checkOutput("t1_n_stable", 64'(eng_n_reads), 64'd3);
      checkOutput("t1_mask_stable", 64'(eng_active_channels), 64'h05);
      checkOutput("t1_rises", 64'(riseCount), 64'd3);
      checkRange("t1_drain_guard", doneCyc - lastFallCyc, 164, 200);

      // 2: contention from rr_ptr=0, req0 re-requests during req1's job
      @(posedge clk); #3 areset = 1'b1;
      @(posedge clk); #3 areset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expGrant.push_back(i);
         expDone.push_back('{id: 8'(i), err: 1'b0});
      end
      expGrant.push_back(0);
      expDone.push_back('{id: 8'd0, err: 1'b0});
      @(posedge clk); #2;
      for (int i = 0; i < 4; i++) applyStimulus(i, 8'(8'h11 << i), 1, 3'd7, 10);
      waitFor("t2_grant1", 1, 3, 500);
      @(posedge clk); #2;
      applyStimulus(0, 8'h80, 2, 3'd1, 10);
      waitFor("t2_done", 0, 6, 3000);

      // 3: zero reads completes without releasing the engine
      rel = relCount;
      expGrant.push_back(2);
      expDone.push_back('{id: 8'd2, err: 1'b0});
      @(posedge clk); #2;
      applyStimulus(2, 8'h03, 0, 3'd0, 10);
      waitFor("t3_done", 0, 7, 100);
      checkOutput("t3_done_latency", 64'(doneCyc - readyCyc), 64'd2);
      checkOutput("t3_no_release", 64'(relCount), 64'(rel));

      // 4: empty channel mask is an error, engine stays parked
      expGrant.push_back(1);
      expDone.push_back('{id: 8'd1, err: 1'b1});
      @(posedge clk); #2;
      applyStimulus(1, 8'h00, 5, 3'd0, 10);
      waitFor("t4_done", 0, 8, 100);
      checkOutput("t4_no_release", 64'(relCount), 64'(rel));

      // 5: engine stalls after one conversion
      stallAfter = 1;
      expGrant.push_back(3);
      expDone.push_back('{id: 8'd3, err: 1'b1});
      @(posedge clk); #2;
      applyStimulus(3, 8'hFF, 4, 3'd3, 20);
      waitFor("t5_done", 0, 9, 3000);
      checkOutput("t5_rises", 64'(riseCount), 64'd1);
      checkRange("t5_timeout_gap", resetRiseCyc - lastRiseCyc, 1000, 1002);
      stallAfter = 0;

      // 6: reset mid-run drops the job; pending req3 is served afterwards
      rel = relCount;
      expGrant.push_back(0);
      @(posedge clk); #2;
      applyStimulus(0, 8'h0F, 4, 3'd0, 50);
      waitFor("t6_release", 2, rel + 1, 100);
      repeat (30) @(negedge clk);
      @(posedge clk); #2;
      applyStimulus(3, 8'h01, 1, 3'd5, 10);
      @(negedge clk); #2 areset = 1'b1;
      #1;
      checkOutput("t6_rst_busy", 64'(busy), 64'd0);
      checkOutput("t6_rst_eng_reset", 64'(eng_reset), 64'd1);
      checkOutput("t6_rst_n_reads", 64'(eng_n_reads), 64'd0);
      checkOutput("t6_rst_period", 64'(eng_sample_period), 64'd0);
      checkOutput("t6_rst_grant_id", 64'(grant_id), 64'd0);
      expGrant.push_back(3);
      expDone.push_back('{id: 8'd3, err: 1'b0});
      repeat (3) @(posedge clk);
      #1 areset = 1'b0;
      waitFor("t6_done", 0, 10, 1000);
      repeat (5) @(negedge clk);

      checkOutput("grants_left", 64'(expGrant.size()), 64'd0);
      checkOutput("dones_left", 64'(expDone.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
